// File: rtl/aemb2_dwb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aemb2_pkg
//  Desc     : Shared definitions for the AEMB2 data-side Wishbone master:
//             access size encodings, controller state enum, lane selects.
//  Revision : 1.0  initial release
// ============================================================================
package aemb2_pkg;

    // Access size encodings; 2'b11 is reserved and behaves as a word.
    localparam logic [1:0] SIZ_BYTE = 2'b00;
    localparam logic [1:0] SIZ_HALF = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;

    // Big-endian lane selects: bit 3 is byte lane 31:24.
    localparam logic [3:0] SEL_BYTE    = 4'b1000;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dwb_state_t;

endpackage
`default_nettype wire

// File: rtl/aemb2_dwb_ctrl_lane.sv
`default_nettype none
// ============================================================================
//  Module   : aemb2_dwb_lane
//  Desc     : Combinational big-endian byte-lane steering for stores and
//             zero-extending extraction for load return data.
//  Revision : 1.0  initial release
// ============================================================================
module aemb2_dwb_lane
    import aemb2_pkg::*;
(
    input  logic [1:0]  i_siz,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdat,
    input  logic [3:0]  i_rsel,
    input  logic [31:0] i_rdat,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdat,
    output logic [31:0] o_rdat
);

    // Store side: lane selects and replicated write data from size/address.
    always_comb begin
        o_sel  = SEL_WORD;
        o_wdat = i_wdat;
        case (i_siz)
            SIZ_BYTE: begin
                o_sel  = SEL_BYTE >> i_lane;
                o_wdat = {4{i_wdat[7:0]}};
            end
            SIZ_HALF: begin
                o_sel  = i_lane[1] ? SEL_HALF_LO : SEL_HALF_HI;
                o_wdat = {2{i_wdat[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: the registered lane selects already encode size and offset,
    // so the extract is keyed directly on them.
    always_comb begin
        o_rdat = i_rdat;
        case (i_rsel)
            4'b1000: o_rdat = {24'h0, i_rdat[31:24]};
            4'b0100: o_rdat = {24'h0, i_rdat[23:16]};
            4'b0010: o_rdat = {24'h0, i_rdat[15:8]};
            4'b0001: o_rdat = {24'h0, i_rdat[7:0]};
            4'b1100: o_rdat = {16'h0, i_rdat[31:16]};
            4'b0011: o_rdat = {16'h0, i_rdat[15:0]};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aemb2_dwb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aemb2_dwb_ctrl
//  Desc     : AEMB2 data-side Wishbone classic master. Captures EX-stage
//             load/store requests, steers byte lanes, runs one bus cycle at
//             a time and returns zero-extended load data. dwb_fb low freezes
//             the pipeline.
//  Config   : AEMB2_DWB_POSTED_WRITE_EN - stores retire without stalling;
//             one request may be held behind an outstanding store.
//  Revision : 1.0  initial release
// ============================================================================
module aemb2_dwb_ctrl
    import aemb2_pkg::*;
#(
    parameter int AEMB_DWB = 32,
    parameter int AEMB_HTX = 1
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  dena,
    input  logic                  gpha,
    input  logic                  xwb_req_i,
    input  logic                  xwb_wre_i,
    input  logic [1:0]            xwb_siz_i,
    input  logic [AEMB_DWB-1:0]   xwb_adr_i,
    input  logic [31:0]           xwb_dat_i,
    output logic [31:0]           xwb_dat_o,
    output logic                  dwb_fb,
    output logic [AEMB_DWB-3:0]   dwb_adr_o,
    output logic [31:0]           dwb_dat_o,
    input  logic [31:0]           dwb_dat_i,
    output logic [3:0]            dwb_sel_o,
    output logic                  dwb_wre_o,
    output logic                  dwb_stb_o,
    output logic                  dwb_cyc_o,
    output logic                  dwb_tga_o,
    input  logic                  dwb_ack_i
);

    dwb_state_t          state_q, state_d;
    logic [AEMB_DWB-3:0] adr_q, adr_d;
    logic [3:0]          sel_q, sel_d;
    logic                wre_q, wre_d;
    logic [31:0]         dat_q, dat_d;
    logic                tga_q, tga_d;
    logic [31:0]         rdat_q, rdat_d;

    logic [3:0]          w_lane_sel;
    logic [31:0]         w_lane_wdat;
    logic [31:0]         w_lane_rdat;
    logic                w_req_ok;
    logic                w_tga_in;
    logic                w_load_new;

    assign w_req_ok = dena & xwb_req_i;
    assign w_tga_in = (AEMB_HTX != 0) ? gpha : 1'b0;

    aemb2_dwb_lane u_lane (
        .i_siz  (xwb_siz_i),
        .i_lane (xwb_adr_i[1:0]),
        .i_wdat (xwb_dat_i),
        .i_rsel (sel_q),
        .i_rdat (dwb_dat_i),
        .o_sel  (w_lane_sel),
        .o_wdat (w_lane_wdat),
        .o_rdat (w_lane_rdat)
    );

    assign dwb_stb_o = (state_q == BUSY);
    assign dwb_cyc_o = dwb_stb_o;
    assign dwb_adr_o = adr_q;
    assign dwb_sel_o = sel_q;
    assign dwb_wre_o = wre_q;
    assign dwb_dat_o = dat_q;
    assign dwb_tga_o = tga_q;
    assign xwb_dat_o = rdat_q;

`ifdef AEMB2_DWB_POSTED_WRITE_EN
    logic                pend_q, pend_d;
    logic [AEMB_DWB-3:0] hadr_q, hadr_d;
    logic [3:0]          hsel_q, hsel_d;
    logic                hwre_q, hwre_d;
    logic [31:0]         hdat_q, hdat_d;
    logic                htga_q, htga_d;
    logic                w_load_hold;
    logic                w_cap_hold;

    // An outstanding store without a held request lets the pipeline run.
    assign dwb_fb = ~dwb_stb_o | dwb_ack_i | (wre_q & ~pend_q);
`else
    assign dwb_fb = ~dwb_stb_o | dwb_ack_i;
`endif

    // Next-state: request capture, ack completion and back-to-back issue.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        wre_d      = wre_q;
        dat_d      = dat_q;
        tga_d      = tga_q;
        rdat_d     = rdat_q;
        w_load_new = 1'b0;
`ifdef AEMB2_DWB_POSTED_WRITE_EN
        pend_d      = pend_q;
        hadr_d      = hadr_q;
        hsel_d      = hsel_q;
        hwre_d      = hwre_q;
        hdat_d      = hdat_q;
        htga_d      = htga_q;
        w_load_hold = 1'b0;
        w_cap_hold  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (w_req_ok) begin
                    w_load_new = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (dwb_ack_i) begin
                    if (!wre_q) begin
                        rdat_d = w_lane_rdat;
                    end
`ifdef AEMB2_DWB_POSTED_WRITE_EN
                    if (pend_q) begin
                        // Issue the held request; a same-edge request refills the slot.
                        w_load_hold = 1'b1;
                        w_cap_hold  = w_req_ok;
                        pend_d      = w_req_ok;
                    end else if (w_req_ok) begin
                        w_load_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wre_q && !pend_q && w_req_ok) begin
                    w_cap_hold = 1'b1;
                    pend_d     = 1'b1;
                end
`else
                    if (w_req_ok) begin
                        w_load_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (w_load_new) begin
            adr_d = xwb_adr_i[AEMB_DWB-1:2];
            sel_d = w_lane_sel;
            wre_d = xwb_wre_i;
            dat_d = w_lane_wdat;
            tga_d = w_tga_in;
        end
`ifdef AEMB2_DWB_POSTED_WRITE_EN
        if (w_load_hold) begin
            adr_d = hadr_q;
            sel_d = hsel_q;
            wre_d = hwre_q;
            dat_d = hdat_q;
            tga_d = htga_q;
        end
        if (w_cap_hold) begin
            hadr_d = xwb_adr_i[AEMB_DWB-1:2];
            hsel_d = w_lane_sel;
            hwre_d = xwb_wre_i;
            hdat_d = w_lane_wdat;
            htga_d = w_tga_in;
        end
`endif
    end

    // State and bus registers; reset abandons any cycle in flight.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            sel_q   <= '0;
            wre_q   <= 1'b0;
            dat_q   <= '0;
            tga_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wre_q   <= wre_d;
            dat_q   <= dat_d;
            tga_q   <= tga_d;
            rdat_q  <= rdat_d;
        end
    end

`ifdef AEMB2_DWB_POSTED_WRITE_EN
    // One-entry holding register for a request arriving behind a store.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            pend_q <= 1'b0;
            hadr_q <= '0;
            hsel_q <= '0;
            hwre_q <= 1'b0;
            hdat_q <= '0;
            htga_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            hadr_q <= hadr_d;
            hsel_q <= hsel_d;
            hwre_q <= hwre_d;
            hdat_q <= hdat_d;
            htga_q <= htga_d;
        end
    end
`endif

endmodule
`default_nettype wire
